// File: rtl/regfile_scoreboard.sv
// Integer register file with NREAD combinational read ports, one write port and a
// pending-write scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-through reads.
module regfile_scoreboard #(
  parameter int XLEN      = 32,
  parameter int ADDR_BITS = 5,
  parameter int NREAD     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREAD*ADDR_BITS-1:0] ra,
  output logic [NREAD*XLEN-1:0]      rd,
  output logic [NREAD-1:0]           rd_ready,
  input  logic                       we,
  input  logic [ADDR_BITS-1:0]       wa,
  input  logic [XLEN-1:0]            wd,
  input  logic                       iss_valid,
  input  logic [ADDR_BITS-1:0]       iss_rd,
  input  logic                       flush,
  output logic [2**ADDR_BITS-1:0]    busy,
  output logic [ADDR_BITS:0]         busy_cnt
);

  localparam int DEPTH = 2**ADDR_BITS;
  localparam logic [ADDR_BITS:0] CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

  logic [XLEN-1:0]    rf_q [DEPTH];
  logic [XLEN-1:0]    rf_d [DEPTH];
  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [ADDR_BITS:0] busy_cnt_q, busy_cnt_d;

  logic wr_en;
  logic iss_en;
  logic set_new;
  logic clr_old;

  assign wr_en  = we && (wa != '0);
  assign iss_en = iss_valid && (iss_rd != '0);

  always_comb begin
    rf_d = rf_q;
    if (wr_en) rf_d[wa] = wd;
  end

  // Priority: flush, then a new producer, then writeback clear.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[wa]     = 1'b0;
    if (iss_en) busy_d[iss_rd] = 1'b1;
    if (flush)  busy_d         = '0;
    busy_d[0] = 1'b0;
  end

  // Count tracks busy_d incrementally; a set and clear on the same register cancel to no change.
  always_comb begin
    set_new    = iss_en && !busy_q[iss_rd];
    clr_old    = wr_en && busy_q[wa] && !(iss_en && (iss_rd == wa));
    busy_cnt_d = busy_cnt_q;
    if (flush) begin
      busy_cnt_d = '0;
    end else if (set_new && !clr_old) begin
      busy_cnt_d = busy_cnt_q + CNT_ONE;
    end else if (clr_old && !set_new) begin
      busy_cnt_d = busy_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < DEPTH; n++) rf_q[n] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int n = 0; n < DEPTH; n++) rf_q[n] <= rf_d[n];
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_comb begin
    rd       = '0;
    rd_ready = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (ra[i*ADDR_BITS +: ADDR_BITS] == '0) begin
        rd[i*XLEN +: XLEN] = '0;
        rd_ready[i]        = 1'b1;
      end else begin
        rd[i*XLEN +: XLEN] = rf_q[ra[i*ADDR_BITS +: ADDR_BITS]];
        rd_ready[i]        = !busy_q[ra[i*ADDR_BITS +: ADDR_BITS]];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wa == ra[i*ADDR_BITS +: ADDR_BITS])) begin
          rd[i*XLEN +: XLEN] = wd;
          rd_ready[i]        = 1'b1;
        end
`endif
      end
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus queues expectations, a monitor
// compares them against the DUT at each falling edge or on an explicit sample request.
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int AB   = 5;
  localparam int NR   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [AB-1:0]   ra0, ra1;
  logic [NR*AB-1:0] ra;
  logic [NR*XLEN-1:0] rd;
  logic [NR-1:0]   rd_ready;
  logic            we;
  logic [AB-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic            iss_valid;
  logic [AB-1:0]   iss_rd;
  logic            flush;
  logic [31:0]     busy;
  logic [AB:0]     busy_cnt;

  assign ra = {ra1, ra0};

  regfile_scoreboard #(.XLEN(XLEN), .ADDR_BITS(AB), .NREAD(NR)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rd_ready(rd_ready),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .flush(flush), .busy(busy), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  localparam int K_RD0 = 0, K_RD1 = 1, K_RDY = 2, K_BUSY = 3, K_CNT = 4;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  event sample_ev;

  task automatic push(input string name, input int kind, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk or sample_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.kind)
          K_RD0:   act = rd[31:0];
          K_RD1:   act = rd[63:32];
          K_RDY:   act = {30'b0, rd_ready};
          K_BUSY:  act = busy;
          default: act = {26'b0, busy_cnt};
        endcase
        vectors++;
        if (act !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    ra0 = 5'd3; ra1 = 5'd5;
    push("reset_rd0", K_RD0, 32'h0);
    push("reset_rd1", K_RD1, 32'h0);
    push("reset_rdy", K_RDY, 32'h3);
    push("reset_busy", K_BUSY, 32'h0);
    push("reset_cnt", K_CNT, 32'h0);
    step();

    rst = 1'b0;
    we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF; ra0 = 5'd0;
    push("x0_rdy", K_RDY, 32'h3);
    step();
    we = 1'b0;
    push("x0_read", K_RD0, 32'h0);
    push("x0_busy", K_BUSY, 32'h0);
    step();

    we = 1'b1; wa = 5'd5; wd = 32'h12345678;
    step();
    we = 1'b0; ra0 = 5'd5; ra1 = 5'd6;
    push("wr5_rd0", K_RD0, 32'h12345678);
    push("x6_rd1", K_RD1, 32'h0);
    step();

    iss_valid = 1'b1; iss_rd = 5'd7; ra0 = 5'd7;
    push("iss7_same_cycle_rdy", K_RDY, 32'h3);
    step();
    iss_valid = 1'b0;
    push("iss7_busy", K_BUSY, 32'h80);
    push("iss7_cnt", K_CNT, 32'h1);
    push("iss7_rdy", K_RDY, 32'h2);
    step();

    we = 1'b1; wa = 5'd7; wd = 32'hA5;
`ifdef REGFILE_BYPASS_EN
    push("wr7_byp_rd0", K_RD0, 32'hA5);
    push("wr7_byp_rdy", K_RDY, 32'h3);
`else
    push("wr7_old_rd0", K_RD0, 32'h0);
    push("wr7_old_rdy", K_RDY, 32'h2);
`endif
    step();
    we = 1'b0;
    push("clr7_busy", K_BUSY, 32'h0);
    push("clr7_cnt", K_CNT, 32'h0);
    push("clr7_rd0", K_RD0, 32'hA5);
    step();

    iss_valid = 1'b1; iss_rd = 5'd3; ra0 = 5'd0; ra1 = 5'd3;
    step();
    iss_valid = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'h55;
    push("byp3_busy", K_BUSY, 32'h8);
`ifdef REGFILE_BYPASS_EN
    push("byp3_rd1", K_RD1, 32'h55);
    push("byp3_rdy", K_RDY, 32'h3);
`else
    push("byp3_rd1", K_RD1, 32'h0);
    push("byp3_rdy", K_RDY, 32'h1);
`endif
    step();
    we = 1'b0;
    push("byp3_after_rd1", K_RD1, 32'h55);
    push("byp3_after_rdy", K_RDY, 32'h3);
    push("byp3_after_cnt", K_CNT, 32'h0);
    step();

    iss_valid = 1'b1; iss_rd = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h99;
    step();
    we = 1'b0; iss_rd = 5'd1;
    push("set_over_clr_busy", K_BUSY, 32'h200);
    push("set_over_clr_cnt", K_CNT, 32'h1);
    step();
    iss_rd = 5'd2;
    step();
    iss_rd = 5'd3;
    step();
    iss_valid = 1'b0;
    push("four_busy", K_BUSY, 32'h20E);
    push("four_cnt", K_CNT, 32'h4);
    step();
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd10; we = 1'b1; wa = 5'd9; wd = 32'h9A;
    step();
    flush = 1'b0; iss_valid = 1'b0; we = 1'b0; ra0 = 5'd9; ra1 = 5'd10;
    push("flush_busy", K_BUSY, 32'h0);
    push("flush_cnt", K_CNT, 32'h0);
    push("flush_wr_rd0", K_RD0, 32'h9A);
    push("flush_iss_rdy", K_RDY, 32'h3);
    step();

    iss_valid = 1'b1; iss_rd = 5'd12;
    step();
    step();
    iss_valid = 1'b0;
    push("waw_busy", K_BUSY, 32'h1000);
    push("waw_cnt", K_CNT, 32'h1);
    we = 1'b1; wa = 5'd12; wd = 32'hC;
    step();
    we = 1'b0;
    push("waw_clr_busy", K_BUSY, 32'h0);
    push("waw_clr_cnt", K_CNT, 32'h0);
    iss_valid = 1'b1; iss_rd = 5'd0;
    step();
    iss_valid = 1'b0;
    push("iss_x0_busy", K_BUSY, 32'h0);
    push("iss_x0_cnt", K_CNT, 32'h0);
    step();

    iss_valid = 1'b1; iss_rd = 5'd4; we = 1'b1; wa = 5'd4; wd = 32'h77;
    step();
    iss_valid = 1'b0; we = 1'b0; ra0 = 5'd4;
    push("pre_rst_rd0", K_RD0, 32'h77);
    push("pre_rst_busy", K_BUSY, 32'h10);
    push("pre_rst_cnt", K_CNT, 32'h1);
    push("pre_rst_rdy", K_RDY, 32'h2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    push("async_rst_rd0", K_RD0, 32'h0);
    push("async_rst_busy", K_BUSY, 32'h0);
    push("async_rst_cnt", K_CNT, 32'h0);
    push("async_rst_rdy", K_RDY, 32'h3);
    -> sample_ev;
    step();
    rst = 1'b0;
    we = 1'b1; wa = 5'd4; wd = 32'h11;
    step();
    we = 1'b0;
    push("post_rst_wr_rd0", K_RD0, 32'h11);
    step();

    @(negedge clk);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
